// File: rtl/elevator_uart_pkg.sv
// Shared constants for the elevator console UART: message codes, ASCII bytes, FSM states.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame (11-bit frames).
package elevator_uart_pkg;

  localparam int CLKRATE_DEF = 434;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam logic [1:0] MSG_ARRIVE = 2'd0;
  localparam logic [1:0] MSG_ACK    = 2'd1;
  localparam logic [1:0] MSG_ERR    = 2'd2;

  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_A     = 8'h41;
  localparam logic [7:0] ASC_R     = 8'h52;
  localparam logic [7:0] ASC_C     = 8'h43;
  localparam logic [7:0] ASC_K     = 8'h4B;
  localparam logic [7:0] ASC_E     = 8'h45;
  localparam logic [7:0] ASC_M     = 8'h4D;
  localparam logic [7:0] ASC_D     = 8'h44;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_0     = 8'h30;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} msg_state_t;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASC_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/uart_status_tx_if.sv
// Event handshake and serial line between the elevator controller and the status transmitter.
interface uart_status_tx_if;
    logic       MSG_VALID;
    logic [1:0] MSG_TYPE;
    logic [5:0] FLOOR;
    logic       MSG_READY;
    logic       TX;
    logic       BUSY;

    modport master (output MSG_VALID, MSG_TYPE, FLOOR, input MSG_READY, TX, BUSY);
    modport slave  (input MSG_VALID, MSG_TYPE, FLOOR, output MSG_READY, TX, BUSY);
endinterface

// File: rtl/uart_tx_byte.sv
// Byte serializer: start, d0..d7, [even parity if UART_TX_PARITY_EN], stop; CLKRATE cycles per bit.
// A start presented on the final stop-bit cycle chains the next frame with no idle gap.
module uart_tx_byte
    import elevator_uart_pkg::*;
#(
    parameter int CLKRATE = CLKRATE_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] data,
    output logic       TX,
    output logic       done,
    output logic       busy
);
    localparam int         CW   = (CLKRATE > 1) ? $clog2(CLKRATE) : 1;
    localparam logic [3:0] LAST = 4'(FRAME_BITS - 1);

    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    data_q;
    logic          bit_end;
    logic          nxt_bit;

    assign bit_end = (cnt == CW'(CLKRATE - 1));
    assign done    = busy && bit_end && (bit_idx == LAST);

    // Value of frame bit bit_idx+1: data bits follow start, then parity/stop.
    always_comb begin
        nxt_bit = 1'b1;
        if (bit_idx < 4'd8) nxt_bit = data_q[bit_idx[2:0]];
`ifdef UART_TX_PARITY_EN
        else if (bit_idx == 4'd8) nxt_bit = ^data_q;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy    <= 1'b0;
            TX      <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            data_q  <= '0;
        end else if (busy && !bit_end) begin
            cnt <= cnt + 1'b1;
        end else if (busy && bit_idx != LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 4'd1;
            TX      <= nxt_bit;
        end else if (start) begin
            busy    <= 1'b1;
            TX      <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            data_q  <= data;
        end else begin
            busy <= 1'b0;
            TX   <= 1'b1;
        end
    end
endmodule

// File: rtl/uart_status_tx.sv
// Elevator status transmitter: latches one event, formats "ARR:dd"/"ACK:dd"/"ERR:CMD" + CR LF, serializes it.
// Frame format follows UART_TX_PARITY_EN (see elevator_uart_pkg).
module uart_status_tx
    import elevator_uart_pkg::*;
#(
    parameter int CLKRATE  = CLKRATE_DEF,
    parameter int MAXFLOOR = 32
) (
    input  logic            CLK,
    input  logic            RST,
    uart_status_tx_if.slave bus
);
    msg_state_t      state;
    logic            ready_q, busy_q;
    logic            ack_q, err_q;
    logic [3:0]      tens_q, ones_q;
    logic [8:0][7:0] buf_q;
    logic [3:0]      msg_len, byte_idx;

    logic [1:0] tens_c;
    logic [3:0] ones_c;
    logic       bad_c;
    logic       last;
    logic       ser_start, ser_done, ser_busy, ser_tx;
    logic [7:0] ser_data;

    assign bus.MSG_READY = ready_q;
    assign bus.BUSY      = busy_q;
    assign bus.TX        = ser_tx;

    // Decimal split valid for floors below 40; anything out of range becomes ERR anyway.
    always_comb begin
        tens_c = (bus.FLOOR >= 6'd30) ? 2'd3 :
                 (bus.FLOOR >= 6'd20) ? 2'd2 :
                 (bus.FLOOR >= 6'd10) ? 2'd1 : 2'd0;
        ones_c = 4'(bus.FLOOR - 6'(tens_c) * 6'd10);
        bad_c  = bus.MSG_TYPE[1] || (bus.FLOOR == 6'd0) || (int'(bus.FLOOR) > MAXFLOOR);
    end

    assign last = (byte_idx == msg_len - 4'd1);

    // On the serializer's done cycle the next byte is handed over so frames run back-to-back.
    always_comb begin
        ser_start = 1'b0;
        ser_data  = buf_q[byte_idx];
        if (state == S_SEND) begin
            if (ser_done) begin
                ser_start = !last;
                if (!last) ser_data = buf_q[byte_idx + 4'd1];
            end else begin
                ser_start = !ser_busy;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            tens_q   <= '0;
            ones_q   <= '0;
            buf_q    <= '0;
            msg_len  <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.MSG_VALID && ready_q) begin
                    ack_q   <= (bus.MSG_TYPE == MSG_ACK);
                    err_q   <= bad_c;
                    tens_q  <= {2'b00, tens_c};
                    ones_q  <= ones_c;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                    state   <= S_LOAD;
                end
                S_LOAD: begin
                    if (err_q) begin
                        buf_q   <= {ASC_LF, ASC_CR, ASC_D, ASC_M, ASC_C, ASC_COLON, ASC_R, ASC_R, ASC_E};
                        msg_len <= 4'd9;
                    end else begin
                        buf_q   <= {8'h00, ASC_LF, ASC_CR, ascii_digit(ones_q), ascii_digit(tens_q),
                                    ASC_COLON, ack_q ? ASC_K : ASC_R, ack_q ? ASC_C : ASC_R, ASC_A};
                        msg_len <= 4'd8;
                    end
                    byte_idx <= '0;
                    state    <= S_SEND;
                end
                S_SEND: if (ser_done) begin
                    if (last) begin
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        byte_idx <= byte_idx + 4'd1;
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    uart_tx_byte #(.CLKRATE(CLKRATE)) u_byte (
        .CLK   (CLK),
        .RST   (RST),
        .start (ser_start),
        .data  (ser_data),
        .TX    (ser_tx),
        .done  (ser_done),
        .busy  (ser_busy)
    );
endmodule

// File: tb/tb_uart_status_tx.sv
// Directed bench for uart_status_tx: decodes TX frames at mid-bit and checks handshake/BUSY timing.
// Follows UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_status_tx;
    localparam int C = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic CLK = 1'b0;
    logic RST;
    int   n_tot = 0;
    int   n_bad = 0;
    int   tx_edges = 0;
    logic tx_prev = 1'b1;
    int   busy_cur = 0;
    int   busy_last = 0;

    uart_status_tx_if bus ();

    uart_status_tx #(.CLKRATE(C), .MAXFLOOR(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.TX !== tx_prev) tx_edges <= tx_edges + 1;
        tx_prev <= bus.TX;
    end

    // Length of the most recent BUSY pulse in cycles.
    always @(posedge CLK or posedge RST) begin
        if (RST) busy_cur <= 0;
        else if (bus.BUSY === 1'b1) busy_cur <= busy_cur + 1;
        else if (busy_cur != 0) begin
            busy_last <= busy_cur;
            busy_cur  <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {21'd0, 1'b1, ^b, b, 1'b0};
`else
        return {22'd0, 1'b1, b, 1'b0};
`endif
    endfunction

    // Request one event, then decode and check every byte plus BUSY/READY timing.
    task automatic run_msg(input logic [1:0] mt, input logic [5:0] fl,
                           input logic [71:0] exp, input int len, input string tag);
        int w, pos, t;
        logic [10:0] fr;
        logic [7:0]  b;
        bus.MSG_TYPE  = mt;
        bus.FLOOR     = fl;
        bus.MSG_VALID = 1'b1;
        w = 0;
        while (bus.MSG_READY !== 1'b1 && w < 5000) begin
            @(negedge CLK);
            w++;
        end
        chk({tag, "_rdy"}, bus.MSG_READY, 1);
        @(posedge CLK);
        #1 bus.MSG_VALID = 1'b0;
        bus.MSG_TYPE = 2'd2;
        bus.FLOOR    = 6'd0;
        @(negedge CLK);
        chk({tag, "_acc"}, {bus.MSG_READY, bus.BUSY}, 2'b01);
        @(negedge CLK);
        chk({tag, "_pre"}, bus.TX, 1);
        @(negedge CLK);
        chk({tag, "_lat"}, bus.TX, 0);
        pos = 0;
        for (int i = 0; i < len; i++) begin
            fr = '0;
            for (int k = 0; k < FB; k++) begin
                t = (i * FB + k) * C + C / 2;
                repeat (t - pos) @(negedge CLK);
                pos = t;
                fr[k] = bus.TX;
            end
            b = exp[(len - 1 - i) * 8 +: 8];
            chk($sformatf("%s_b%0d", tag, i), {21'd0, fr}, frame_of(b));
        end
        w = 0;
        while (bus.BUSY !== 1'b0 && w < 4 * FB * C) begin
            @(negedge CLK);
            w++;
        end
        chk({tag, "_bend"}, bus.BUSY, 0);
        @(negedge CLK);
        chk({tag, "_rret"}, bus.MSG_READY, 1);
        chk({tag, "_blen"}, busy_last, 2 + len * FB * C);
    endtask

    initial begin
        int e0, w;
        bus.MSG_VALID = 1'b0;
        bus.MSG_TYPE  = 2'd0;
        bus.FLOOR     = 6'd0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_tx", bus.TX, 1);
        chk("rst_rdy", bus.MSG_READY, 1);
        chk("rst_busy", bus.BUSY, 0);
        RST = 1'b0;
        @(negedge CLK);
        e0 = tx_edges;
        repeat (2000) @(negedge CLK);
        chk("idle_edges", tx_edges - e0, 0);
        chk("idle_state", {bus.TX, bus.MSG_READY, bus.BUSY}, 3'b110);

        run_msg(2'd0, 6'd5,  72'h00_4152523A30350D0A, 8, "arr05");
        run_msg(2'd1, 6'd32, 72'h00_41434B3A33320D0A, 8, "ack32");
        run_msg(2'd0, 6'd33, 72'h4552523A434D440D0A, 9, "arr33");
        run_msg(2'd1, 6'd0,  72'h4552523A434D440D0A, 9, "ack00");
        run_msg(2'd2, 6'd5,  72'h4552523A434D440D0A, 9, "err");
        run_msg(2'd3, 6'd12, 72'h4552523A434D440D0A, 9, "rsv");

        // Stray pulse mid-message is ignored; a request held through the end is taken immediately.
        fork
            run_msg(2'd1, 6'd19, 72'h00_41434B3A31390D0A, 8, "ack19");
            begin
                repeat (100) @(negedge CLK);
                bus.MSG_TYPE  = 2'd2;
                bus.FLOOR     = 6'd0;
                bus.MSG_VALID = 1'b1;
                @(negedge CLK);
                bus.MSG_VALID = 1'b0;
                repeat (400) @(negedge CLK);
                bus.MSG_TYPE  = 2'd0;
                bus.FLOOR     = 6'd20;
                bus.MSG_VALID = 1'b1;
            end
        join
        chk("held_vld", bus.MSG_VALID, 1);
        run_msg(2'd0, 6'd20, 72'h00_4152523A32300D0A, 8, "held20");

        // Reset in the middle of byte 3 (':' = 3A, d2 = 0 so TX is low there).
        bus.MSG_TYPE  = 2'd0;
        bus.FLOOR     = 6'd5;
        bus.MSG_VALID = 1'b1;
        w = 0;
        while (bus.MSG_READY !== 1'b1 && w < 5000) begin
            @(negedge CLK);
            w++;
        end
        @(posedge CLK);
        #1 bus.MSG_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        repeat ((3 * FB + 3) * C + C / 2) @(negedge CLK);
        chk("mid_txlow", bus.TX, 0);
        #2 RST = 1'b1;
        #1 chk("mid_rst", {bus.TX, bus.MSG_READY, bus.BUSY}, 3'b110);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        e0 = tx_edges;
        repeat (300) @(negedge CLK);
        chk("mid_quiet", tx_edges - e0, 0);
        run_msg(2'd0, 6'd7, 72'h00_4152523A30370D0A, 8, "arr07");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_status_tx.md
Name: uart_status_tx

Overview:
- Transmit side of the elevator console link (115200 8N1). Complements the command receiver.
- Accepts one status event at a time from the elevator controller FSM, formats it as an ASCII line, and serializes it LSB-first on TX.
- Sits between the controller and the FPGA UART TX pin; the terminal displays controller responses (arrival, call acknowledge, error).

Parameters:
- CLKRATE, 434, clock cycles per bit (50 MHz / 115200).
- MAXFLOOR, 32, highest valid floor; valid range is 1..MAXFLOOR.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- MSG_VALID  in  1  event request; held until accepted.
- MSG_TYPE  in  2  0 = ARRIVE, 1 = ACK (call registered), 2 = ERR, 3 = reserved (treated as ERR).
- FLOOR  in  6  floor number for ARRIVE/ACK.
- MSG_READY  out  1  high when idle and able to accept an event.
- TX  out  1  serial line; idle high.
- BUSY  out  1  high from acceptance until the last stop bit ends.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset values: TX=1, MSG_READY=1, BUSY=0. Internal counters and the message buffer clear to 0.
- Reset mid-frame aborts immediately. TX returns high asynchronously and no partial byte resumes.
- Handshake:
  - An event is accepted on a rising edge where MSG_VALID & MSG_READY.
  - MSG_TYPE and FLOOR are latched on that edge.
  - MSG_READY drops and BUSY rises on the next cycle. The inputs are don't-care afterwards.
- Message formats (ASCII; dd is two decimal digits with a leading zero):
  - ARRIVE: "ARR:dd" CR LF, 8 bytes.
  - ACK: "ACK:dd" CR LF, 8 bytes.
  - ERR: "ERR:CMD" CR LF, 9 bytes.
- Invalid floor: ARRIVE/ACK with FLOOR==0 or FLOOR>MAXFLOOR sends the ERR message instead.
- Decimal conversion at latch time: tens = FLOOR>=30 ? 3 : FLOOR>=20 ? 2 : FLOOR>=10 ? 1 : 0; ones = FLOOR - 10*tens. Digits are +8'h30.
- Message FSM states:
  - IDLE -> LOAD on accept.
  - LOAD builds the byte buffer (9 x 8 bits), sets msg_len to 8 or 9 and byte_idx to 0, then goes to SEND.
  - SEND hands the byte at byte_idx to the byte serializer and waits for its done pulse. It increments byte_idx and goes to DONE when byte_idx==msg_len-1 completes.
  - DONE asserts MSG_READY and returns to IDLE.
- Bit timing (byte serializer):
  - Frame is start(0), d0..d7, stop(1); each bit lasts exactly CLKRATE cycles.
  - Consecutive bytes are back-to-back with no idle gap: byte n+1's start bit begins the cycle after byte n's stop bit ends.
- Latency and total time:
  - TX falls (start bit of byte 0) 2 cycles after the accepting edge.
  - Total BUSY time = 2 + msg_len*10*CLKRATE cycles, i.e. 34722 cycles for 8 bytes and 39062 for 9 bytes at the default.
- MSG_VALID asserted while BUSY is ignored, not queued; the requester must hold it.
- TX is registered and glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of d0..d7) is inserted between d7 and stop. Frame becomes 11 bits, so BUSY = 2 + msg_len*11*CLKRATE.
- Undefined: plain 8N1 as above.

Decomposition:
- Shared package/header elevator_uart_pkg:
  - CLKRATE default.
  - MSG_TYPE encodings (MSG_ARRIVE, MSG_ACK, MSG_ERR).
  - ASCII constants (CR=8'h0D, LF=8'h0A, 'A','R','C','K','E','M','D',':', digit base 8'h30).
  - Message FSM state encodings.
- Sub-module uart_tx_byte: byte serializer.
  - Inputs: CLK, RST, start, data[7:0].
  - Outputs: TX, done pulse, busy.
  - Owns the bit counter and the CLKRATE divider.
- uart_status_tx owns formatting, the message FSM and the handshake.

Test Plan:
- Reset during idle, then release -> TX=1, MSG_READY=1, BUSY=0, no TX edge for 10000 cycles.
- MSG_TYPE=0, FLOOR=5 -> bytes 41 52 52 3A 30 35 0D 0A decoded by a bench UART RX; BUSY high for 34722 cycles; MSG_READY returns after that.
- MSG_TYPE=1, FLOOR=32 -> "ACK:32" CR LF; MSG_TYPE=0, FLOOR=33 and FLOOR=0 -> "ERR:CMD" CR LF (9 bytes, 39062 cycles).
- Second MSG_VALID pulse mid-message -> ignored, output identical to a single message; a held MSG_VALID is accepted the cycle MSG_READY returns.
- RST asserted during bit 4 of byte 3 -> TX high immediately; new request after release sends a complete correct message.
- With UART_TX_PARITY_EN, FLOOR=7 ARRIVE -> parity bit per byte correct (e.g. '7'=8'h37 -> parity 1), frame 11*CLKRATE per byte.
